// File: rtl/csma_backoff_pkg.sv
// -----------------------------------------------------------------------------
// csma_backoff_pkg
// Shared definitions for the CSMA/CA backoff engine:
//   - state_e       : engine state encoding (IDLE, SENSE, BACKOFF, GRANT, TX)
//   - LFSR_TAPS_16  : tap mask for x^16+x^14+x^13+x^11+1
//   - LFSR_TAPS_32  : tap mask for x^32+x^22+x^2+x+1
//   - window_mask() : (2^exp)-1 contention-window mask, 64 bits wide so any
//                     counter width up to 64 can slice it
// -----------------------------------------------------------------------------
package csma_backoff_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SENSE   = 3'd1,
        BACKOFF = 3'd2,
        GRANT   = 3'd3,
        TX      = 3'd4
    } state_e;

    // Bit i set means stage i+1 of the polynomial feeds back (shift-left form).
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    localparam int MASK_W = 64;

    function automatic logic [MASK_W-1:0] window_mask(input logic [6:0] exp_val);
        window_mask = (64'd1 << exp_val) - 64'd1;
    endfunction

endpackage

// File: rtl/backoff_lfsr.sv
// -----------------------------------------------------------------------------
// backoff_lfsr
// Free-running Fibonacci LFSR supplying the random part of each backoff draw.
// Advances every clk; while rst is high it holds the seed (0 replaced by 1 so
// the register can never lock up in the all-zero state).
// Ports:
//   clk   in  1 : clock
//   rst   in  1 : asynchronous active-high reset / seed load
//   seed  in  W : seed value
//   value out W : current LFSR state
// W = 32 selects the 32-bit polynomial, any other value the 16-bit one.
// -----------------------------------------------------------------------------
module backoff_lfsr
    import csma_backoff_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] seed,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] TAPS = (W == 32) ? W'(LFSR_TAPS_32) : W'(LFSR_TAPS_16);

    logic [W-1:0] value_r;
    logic [W-1:0] seed_s;
    logic [W-1:0] next_s;
    logic         fb_s;

    // Seed sanitising and next-state feedback
    always_comb begin
        if (seed == {W{1'b0}}) begin
            seed_s = W'(1'b1);
        end else begin
            seed_s = seed;
        end
        fb_s   = ^(value_r & TAPS);
        next_s = {value_r[W-2:0], fb_s};
    end

    // LFSR state register, seeded while reset is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= seed_s;
        end else begin
            value_r <= next_s;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/csma_backoff_engine.sv
// -----------------------------------------------------------------------------
// csma_backoff_engine
// CSMA/CA backoff engine sitting between the carrier-sense detector and the TX
// burst controller. It gates the carrier-present indication seen by the TX
// path, draws a random slot backoff from an LFSR, grows the contention window
// exponentially on each draw and drops the frame when retries run out.
// Optional statistics counters are built when CSMA_BACKOFF_STATS_EN is defined.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   strobe                    : one-clk slot tick
//   enable                    : 0 forces IDLE / transparent pass-through
//   run_tx, run_rx            : TX burst running, RX running
//   burst_done                : end-of-burst pulse (honoured only in TX)
//   data_waiting              : frame queued
//   max_backoff [CNT_W]       : cap ANDed into the contention window
//   carrier_present_from_CS   : raw carrier sense
//   seed [LFSR_W]             : LFSR seed (loaded during rst)
//   carrier_present_out       : busy indication to TX path (registered)
//   backoff_active            : high in SENSE and BACKOFF (registered)
//   retry_count [RETRY_W]     : deferrals for the current frame
//   drop                      : one-clk pulse when retries are exhausted
//   collision_count, drop_count [16] : saturating stats (0 when disabled)
// -----------------------------------------------------------------------------
module csma_backoff_engine
    import csma_backoff_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int LFSR_W      = 16,
    parameter int MIN_EXP     = 4,
    parameter int MAX_EXP     = 10,
    parameter int RETRY_W     = 4,
    parameter int MAX_RETRIES = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               strobe,
    input  logic               enable,
    input  logic               run_tx,
    input  logic               run_rx,
    input  logic               burst_done,
    input  logic               data_waiting,
    input  logic [CNT_W-1:0]   max_backoff,
    input  logic               carrier_present_from_CS,
    input  logic [LFSR_W-1:0]  seed,
    output logic               carrier_present_out,
    output logic               backoff_active,
    output logic [RETRY_W-1:0] retry_count,
    output logic               drop,
    output logic [15:0]        collision_count,
    output logic [15:0]        drop_count
);

    localparam int EXP_W = $clog2(CNT_W + 1);

    state_e             state_r, state_nxt_s;
    logic [EXP_W-1:0]   exp_r, exp_nxt_s, exp_inc_s;
    logic [RETRY_W-1:0] retry_r, retry_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s, lfsr_ext_s, window_s;
    logic [LFSR_W-1:0]  lfsr_value_s;
    logic               busy_s, draw_s, dec_s, clr_s, drop_nxt_s;
    logic               cpo_r, cpo_nxt_s, active_r, active_nxt_s, drop_r;

    backoff_lfsr #(.W(LFSR_W)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (seed),
        .value (lfsr_value_s)
    );

    // Medium busy, saturating exponent step and current draw window
    always_comb begin
        busy_s     = carrier_present_from_CS | run_rx;
        lfsr_ext_s = CNT_W'(lfsr_value_s);
        window_s   = CNT_W'(window_mask(7'(exp_r))) & max_backoff;
        if (exp_r >= EXP_W'(MAX_EXP)) begin
            exp_inc_s = EXP_W'(MAX_EXP);
        end else begin
            exp_inc_s = exp_r + EXP_W'(1'b1);
        end
    end

    // Next-state logic; SENSE samples the medium only at slot ticks
    always_comb begin
        state_nxt_s = state_r;
        exp_nxt_s   = exp_r;
        retry_nxt_s = retry_r;
        draw_s      = 1'b0;
        dec_s       = 1'b0;
        clr_s       = 1'b0;
        drop_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable && data_waiting) begin
                    state_nxt_s = SENSE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SENSE, BACKOFF: begin
                if (!enable || !data_waiting) begin
                    state_nxt_s = IDLE;
                    exp_nxt_s   = EXP_W'(MIN_EXP);
                    retry_nxt_s = {RETRY_W{1'b0}};
                    clr_s       = 1'b1;
                end else if (state_r == SENSE && strobe && busy_s) begin
                    draw_s      = 1'b1;
                    exp_nxt_s   = exp_inc_s;
                    state_nxt_s = BACKOFF;
                end else if (strobe && !busy_s) begin
                    // count==0 at an idle tick ends the backoff
                    if (state_r == SENSE || count_r == {CNT_W{1'b0}}) begin
                        state_nxt_s = GRANT;
                    end else begin
                        dec_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            GRANT: begin
                if (!enable) begin
                    state_nxt_s = IDLE;
                    exp_nxt_s   = EXP_W'(MIN_EXP);
                    retry_nxt_s = {RETRY_W{1'b0}};
                    clr_s       = 1'b1;
                end else if (run_tx) begin
                    state_nxt_s = TX;
                end else if (busy_s) begin
                    if (retry_r == RETRY_W'(MAX_RETRIES)) begin
                        drop_nxt_s  = 1'b1;
                        state_nxt_s = IDLE;
                        exp_nxt_s   = EXP_W'(MIN_EXP);
                        retry_nxt_s = {RETRY_W{1'b0}};
                        clr_s       = 1'b1;
                    end else begin
                        retry_nxt_s = retry_r + RETRY_W'(1'b1);
                        draw_s      = 1'b1;
                        exp_nxt_s   = exp_inc_s;
                        state_nxt_s = BACKOFF;
                    end
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            TX: begin
                if (!enable || burst_done) begin
                    state_nxt_s = IDLE;
                    exp_nxt_s   = EXP_W'(MIN_EXP);
                    retry_nxt_s = {RETRY_W{1'b0}};
                    clr_s       = 1'b1;
                end else begin
                    state_nxt_s = TX;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                exp_nxt_s   = EXP_W'(MIN_EXP);
                retry_nxt_s = {RETRY_W{1'b0}};
                clr_s       = 1'b1;
            end
        endcase
    end

    // Backoff counter next value
    always_comb begin
        if (draw_s) begin
            count_nxt_s = lfsr_ext_s & window_s;
        end else if (clr_s) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (dec_s) begin
            count_nxt_s = count_r - CNT_W'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Outputs decoded from the next state so they register with it
    always_comb begin
        case (state_nxt_s)
            IDLE:           cpo_nxt_s = busy_s;
            SENSE, BACKOFF: cpo_nxt_s = 1'b1;
            default:        cpo_nxt_s = 1'b0;
        endcase
        active_nxt_s = (state_nxt_s == SENSE) || (state_nxt_s == BACKOFF);
    end

    // State and registered output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            exp_r    <= EXP_W'(MIN_EXP);
            retry_r  <= {RETRY_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            cpo_r    <= 1'b1;
            active_r <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            exp_r    <= exp_nxt_s;
            retry_r  <= retry_nxt_s;
            count_r  <= count_nxt_s;
            cpo_r    <= cpo_nxt_s;
            active_r <= active_nxt_s;
            drop_r   <= drop_nxt_s;
        end
    end

    assign carrier_present_out = cpo_r;
    assign backoff_active      = active_r;
    assign retry_count         = retry_r;
    assign drop                = drop_r;

`ifdef CSMA_BACKOFF_STATS_EN
    logic [15:0] collision_cnt_r, drop_cnt_r;

    // Saturating draw and drop statistics, cleared only by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision_cnt_r <= 16'd0;
            drop_cnt_r      <= 16'd0;
        end else begin
            if (draw_s && collision_cnt_r != 16'hFFFF) begin
                collision_cnt_r <= collision_cnt_r + 16'd1;
            end
            if (drop_nxt_s && drop_cnt_r != 16'hFFFF) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    assign collision_count = collision_cnt_r;
    assign drop_count      = drop_cnt_r;
`else
    assign collision_count = 16'd0;
    assign drop_count      = 16'd0;
`endif

endmodule

// File: tb/tb_csma_backoff_engine.sv
// -----------------------------------------------------------------------------
// tb_csma_backoff_engine
// Directed self-checking bench for csma_backoff_engine (default parameters).
// Draw values are predicted from an LFSR model built from the 16-bit
// polynomial x^16+x^14+x^13+x^11+1, reset and clocked alongside the DUT.
// Honours CSMA_BACKOFF_STATS_EN for the statistics expectations.
// -----------------------------------------------------------------------------
module tb_csma_backoff_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0, enable = 1'b0, run_tx = 1'b0, run_rx = 1'b0;
    logic        burst_done = 1'b0, data_waiting = 1'b0, carrier = 1'b0;
    logic [31:0] max_backoff = 32'h0000_07FF;
    logic [15:0] seed = 16'hACE1;
    logic        cpo, active, drop;
    logic [3:0]  retry;
    logic [15:0] coll_cnt, drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] lfsr_m;
    logic [31:0] exp_cnt, win;
    int          n;

    csma_backoff_engine dut (
        .clk                     (clk),
        .rst                     (rst),
        .strobe                  (strobe),
        .enable                  (enable),
        .run_tx                  (run_tx),
        .run_rx                  (run_rx),
        .burst_done              (burst_done),
        .data_waiting            (data_waiting),
        .max_backoff             (max_backoff),
        .carrier_present_from_CS (carrier),
        .seed                    (seed),
        .carrier_present_out     (cpo),
        .backoff_active          (active),
        .retry_count             (retry),
        .drop                    (drop),
        .collision_count         (coll_cnt),
        .drop_count              (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference LFSR: shift left, feedback from stages 16,14,13,11
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= (seed == 16'd0) ? 16'd1 : seed;
        else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle strobes until carrier_present_out falls; n=-1 if budget expires
    task automatic strobes_to_grant(input int budget, input bit busy_between, output int cnt);
        bit granted;
        granted = 1'b0;
        cnt = 0;
        for (int i = 0; i < budget && !granted; i++) begin
            strobe = 1'b1; carrier = 1'b0;
            tick();
            strobe = 1'b0;
            cnt++;
            if (cpo == 1'b0) begin
                granted = 1'b1;
            end else begin
                if (busy_between) begin
                    carrier = 1'b1; strobe = 1'b1;
                    tick();
                    strobe = 1'b0; carrier = 1'b0;
                end
                tick();
            end
        end
        if (!granted) cnt = -1;
    endtask

    task automatic finish_tx();
        run_tx = 1'b1;
        tick();
        burst_done = 1'b1; data_waiting = 1'b0;
        tick();
        burst_done = 1'b0; run_tx = 1'b0;
        tick();
    endtask

    // Enter SENSE then draw with busy coinciding with a strobe
    task automatic sense_busy_draw(input logic [31:0] window);
        data_waiting = 1'b1;
        tick();
        exp_cnt = {16'd0, lfsr_m} & window & max_backoff;
        carrier = 1'b1; strobe = 1'b1;
        tick();
        strobe = 1'b0; carrier = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cpo",    32'(cpo), 32'd1);
        check_eq("rst_active", 32'(active), 32'd0);
        check_eq("rst_retry",  32'(retry), 32'd0);
        check_eq("rst_drop",   32'(drop), 32'd0);
        check_eq("rst_coll",   32'(coll_cnt), 32'd0);
        check_eq("rst_dcnt",   32'(drop_cnt), 32'd0);
        rst = 1'b0; enable = 1'b1;
        tick();
        check_eq("idle_pass_low", 32'(cpo), 32'd0);
        carrier = 1'b1; tick();
        check_eq("idle_pass_cs", 32'(cpo), 32'd1);
        carrier = 1'b0; run_rx = 1'b1; tick();
        check_eq("idle_pass_rx", 32'(cpo), 32'd1);
        run_rx = 1'b0; tick();

        // Idle medium: grant on the first strobe
        data_waiting = 1'b1; tick();
        check_eq("sense_active", 32'(active), 32'd1);
        check_eq("sense_cpo", 32'(cpo), 32'd1);
        strobe = 1'b1; tick(); strobe = 1'b0;
        check_eq("grant_cpo", 32'(cpo), 32'd0);
        check_eq("grant_active", 32'(active), 32'd0);
        run_tx = 1'b1; tick();
        check_eq("tx_cpo", 32'(cpo), 32'd0);
        burst_done = 1'b1; data_waiting = 1'b0; tick();
        burst_done = 1'b0; run_tx = 1'b0;
        check_eq("tx_done_retry", 32'(retry), 32'd0);
        check_eq("tx_done_active", 32'(active), 32'd0);
        tick();
        check_eq("tx_done_idle_cpo", 32'(cpo), 32'd0);

        // Busy in SENSE: count+1 idle strobes to grant
        sense_busy_draw(32'd15);
        check_eq("bo_active", 32'(active), 32'd1);
        strobes_to_grant(40, 1'b0, n);
        check_eq("bo_strobes", 32'(n), exp_cnt + 32'd1);
        finish_tx();

        // Busy strobes during backoff freeze the count
        sense_busy_draw(32'd15);
        carrier = 1'b1;
        repeat (3) begin
            strobe = 1'b1; tick(); strobe = 1'b0; tick();
        end
        check_eq("frozen_cpo", 32'(cpo), 32'd1);
        carrier = 1'b0;
        strobes_to_grant(40, 1'b1, n);
        check_eq("frozen_strobes", 32'(n), exp_cnt + 32'd1);
        finish_tx();

        // Eight busy events in GRANT: windows grow, then drop
        sense_busy_draw(32'd15);
        strobes_to_grant(40, 1'b0, n);
        check_eq("win15_strobes", 32'(n), exp_cnt + 32'd1);
        for (int k = 1; k <= 7; k++) begin
            win = (k >= 6) ? 32'd1023 : ((32'd1 << (4 + k)) - 32'd1);
            exp_cnt = {16'd0, lfsr_m} & win;
            carrier = 1'b1; tick(); carrier = 1'b0;
            check_eq($sformatf("defer%0d_retry", k), 32'(retry), 32'(k));
            strobes_to_grant(1100, 1'b0, n);
            check_eq($sformatf("defer%0d_strobes", k), 32'(n), exp_cnt + 32'd1);
        end
        carrier = 1'b1; tick();
        check_eq("drop_pulse", 32'(drop), 32'd1);
        check_eq("drop_active", 32'(active), 32'd0);
        carrier = 1'b0; data_waiting = 1'b0; tick();
        check_eq("drop_single", 32'(drop), 32'd0);
        check_eq("drop_idle_cpo", 32'(cpo), 32'd0);
`ifdef CSMA_BACKOFF_STATS_EN
        check_eq("stat_coll", 32'(coll_cnt), 32'd8);
        check_eq("stat_drop", 32'(drop_cnt), 32'd1);
`else
        check_eq("stat_coll", 32'(coll_cnt), 32'd0);
        check_eq("stat_drop", 32'(drop_cnt), 32'd0);
`endif

        // max_backoff = 0: every draw is 0
        max_backoff = 32'd0;
        sense_busy_draw(32'd15);
        strobes_to_grant(8, 1'b0, n);
        check_eq("mb0_sense", 32'(n), 32'd1);
        carrier = 1'b1; tick(); carrier = 1'b0;
        check_eq("mb0_retry", 32'(retry), 32'd1);
        strobes_to_grant(8, 1'b0, n);
        check_eq("mb0_grant", 32'(n), 32'd1);
        finish_tx();
        max_backoff = 32'h0000_07FF;

        // Asynchronous reset mid-BACKOFF
        data_waiting = 1'b1; tick();
        strobe = 1'b1; tick(); strobe = 1'b0;
        carrier = 1'b1; tick(); carrier = 1'b0;
        check_eq("pre_rst_retry", 32'(retry), 32'd1);
        burst_done = 1'b1; tick(); burst_done = 1'b0;
        check_eq("bd_ignored", 32'(active), 32'd1);
        #2; rst = 1'b1; #1;
        check_eq("arst_cpo", 32'(cpo), 32'd1);
        check_eq("arst_retry", 32'(retry), 32'd0);
        check_eq("arst_active", 32'(active), 32'd0);
        rst = 1'b0;
        tick();

        // enable=0 mid-BACKOFF: transparent pass-through
        sense_busy_draw(32'd15);
        check_eq("en_bo_active", 32'(active), 32'd1);
        enable = 1'b0; tick();
        check_eq("en0_cpo_low", 32'(cpo), 32'd0);
        check_eq("en0_active", 32'(active), 32'd0);
        carrier = 1'b1; tick();
        check_eq("en0_cpo_high", 32'(cpo), 32'd1);
        carrier = 1'b0; tick();
        check_eq("en0_cpo_fall", 32'(cpo), 32'd0);
        data_waiting = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
